// File: rtl/wm8731_adc_capture.sv
// WM8731 ADC receive stage: generates BCLK/ADCLRC for a slave codec,
// deserialises left-justified 16+16 bit frames from ADCDAT and buffers
// the resulting {left, right} words in a FIFO that the bus pops one word
// per read.
module wm8731_adc_capture #(
   parameter int BCLK_DIV = 16,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic             adc_bclk,
   output logic             adc_lrc,
   input  logic             adc_dat,
   input  logic             rd_en,
   output logic [31:0]      rd_data,
   output logic             rd_valid,
   output logic             empty,
   output logic             full,
   output logic [CNT_W-1:0] count,
   output logic             ovf,
   input  logic             ovf_clr
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DIV_W-1:0] div_cnt_r;
   logic             bclk_r;
   logic             lrc_r;
   logic [4:0]       bit_cnt_r;
   logic [31:0]      shift_r;
   logic             push_r;
   logic [31:0]      push_data_r;

   logic [31:0]      mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             empty_r;
   logic             full_r;
   logic [31:0]      rd_data_r;
   logic             rd_valid_r;
   logic             ovf_r;

   logic             wrap_s;
   logic             rise_tick_s;
   logic             fall_tick_s;
   logic [4:0]       bit_cnt_nxt_s;
   logic [31:0]      shift_nxt_s;
   logic             do_push_s;
   logic             do_pop_s;
   logic             overflow_s;
   logic [CNT_W-1:0] count_nxt_s;

   assign wrap_s        = (div_cnt_r == DIV_W'(BCLK_DIV - 1));
   assign rise_tick_s   = en & wrap_s & ~bclk_r;
   assign fall_tick_s   = en & wrap_s & bclk_r;
   assign bit_cnt_nxt_s = bit_cnt_r + 5'd1;
   assign shift_nxt_s   = {shift_r[30:0], adc_dat};

   // A pop needs data; a push needs room unless a pop frees a slot in the same cycle.
   assign do_pop_s   = rd_en & ~empty_r;
   assign do_push_s  = push_r & (~full_r | do_pop_s);
   assign overflow_s = push_r & full_r & ~do_pop_s;

   // Next fill level from the push/pop combination.
   always_comb begin
      count_nxt_s = count_r;
      case ({do_push_s, do_pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Bit-clock divider, frame counter, LR clock and serial shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_r <= '0;
         bclk_r    <= 1'b0;
         lrc_r     <= 1'b1;
         bit_cnt_r <= 5'd0;
         shift_r   <= 32'd0;
      end else if (!en) begin
         // Disabling restarts the frame and throws away any partial word.
         div_cnt_r <= '0;
         bclk_r    <= 1'b0;
         lrc_r     <= 1'b1;
         bit_cnt_r <= 5'd0;
         shift_r   <= 32'd0;
      end else begin
         div_cnt_r <= wrap_s ? '0 : div_cnt_r + DIV_W'(1);
         if (wrap_s) begin
            bclk_r <= ~bclk_r;
         end
         if (fall_tick_s) begin
            bit_cnt_r <= bit_cnt_nxt_s;
            lrc_r     <= ~bit_cnt_nxt_s[4];
         end
         if (rise_tick_s) begin
            shift_r <= shift_nxt_s;
         end
      end
   end

   // Word completion: the last right-channel bit raises a push for one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         push_r      <= 1'b0;
         push_data_r <= 32'd0;
      end else begin
         push_r <= rise_tick_s & (bit_cnt_r == 5'd31);
         if (rise_tick_s && (bit_cnt_r == 5'd31)) begin
            push_data_r <= shift_nxt_s;
         end
      end
   end

   // FIFO storage; contents are qualified by the pointers so need no reset.
   always_ff @(posedge clk) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data_r;
      end
   end

   // FIFO pointers, fill level, flags, read port and sticky overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         rd_data_r  <= 32'd0;
         rd_valid_r <= 1'b0;
         ovf_r      <= 1'b0;
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r  <= rd_ptr_r + AW'(1);
            rd_data_r <= mem_r[rd_ptr_r];
         end
         rd_valid_r <= do_pop_s;
         count_r    <= count_nxt_s;
         empty_r    <= (count_nxt_s == CNT_W'(0));
         full_r     <= (count_nxt_s == CNT_W'(DEPTH));
         // A new overflow outranks a clear arriving in the same cycle.
         if (overflow_s) begin
            ovf_r <= 1'b1;
         end else if (ovf_clr) begin
            ovf_r <= 1'b0;
         end
      end
   end

   assign adc_bclk = bclk_r;
   assign adc_lrc  = lrc_r;
   assign rd_data  = rd_data_r;
   assign rd_valid = rd_valid_r;
   assign empty    = empty_r;
   assign full     = full_r;
   assign count    = count_r;
   assign ovf      = ovf_r;

endmodule
